// File: rtl/rs_multi_cdb.sv
// Reservation station for ALU ops: captures operands from NUM_CDB broadcast channels and
// issues the oldest ready entry through a registered, stallable issue slot.
module rs_multi_cdb #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 3,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 5
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*(ROB_W+1)-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]        cdb_value,
  input  logic                         dis_valid,
  input  logic [OP_W-1:0]              dis_op,
  input  logic [ROB_W-1:0]             dis_rob_id,
  input  logic [ROB_W:0]               dis_q1,
  input  logic [ROB_W:0]               dis_q2,
  input  logic [31:0]                  dis_v1,
  input  logic [31:0]                  dis_v2,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [OP_W-1:0]              iss_op,
  output logic [31:0]                  iss_opr1,
  output logic [31:0]                  iss_opr2,
  output logic [ROB_W:0]               iss_tag,
  output logic [$clog2(DEPTH):0]       count_out,
  output logic                         full_out
);

  localparam int TW = ROB_W + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] NO_DEP = '1;

  logic [DEPTH-1:0] busy;
  logic [OP_W-1:0]  e_op  [DEPTH];
  logic [ROB_W-1:0] e_rob [DEPTH];
  logic [TW-1:0]    e_q1  [DEPTH];
  logic [TW-1:0]    e_q2  [DEPTH];
  logic [31:0]      e_v1  [DEPTH];
  logic [31:0]      e_v2  [DEPTH];
  // older[i][j] set: entry i was dispatched before entry j
  logic [DEPTH-1:0] older [DEPTH];

  logic [DEPTH-1:0] ready, acc_mask, sel_mask;
  logic [DEPTH-1:0] w1_hit, w2_hit;
  logic [31:0]      w1_val [DEPTH];
  logic [31:0]      w2_val [DEPTH];
  logic             d1_hit, d2_hit;
  logic [31:0]      d1_val, d2_val;
  logic [IW-1:0]    free_idx, sel_idx;
  logic             sel_any, accept, advance, do_sel;

  function automatic logic [32:0] cdb_lookup(
    input logic [TW-1:0]         q,
    input logic [NUM_CDB-1:0]    vld,
    input logic [NUM_CDB*TW-1:0] tags,
    input logic [NUM_CDB*32-1:0] vals
  );
    logic [32:0] r;
    r = '0;
    if (q != NO_DEP)
      for (int unsigned k = 0; k < NUM_CDB; k++)
        if (!r[32] && vld[k] && tags[k*TW +: TW] == q)
          r = {1'b1, vals[k*32 +: 32]};
    return r;
  endfunction

  assign full_out = (count_out == CW'(DEPTH));
  assign accept   = dis_valid && !full_out;
  assign advance  = !iss_valid || iss_ready;
  assign do_sel   = advance && sel_any;

  always_comb begin
    w1_hit = '0;
    w2_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      {w1_hit[i], w1_val[i]} = cdb_lookup(e_q1[i], cdb_valid, cdb_tag, cdb_value);
      {w2_hit[i], w2_val[i]} = cdb_lookup(e_q2[i], cdb_valid, cdb_tag, cdb_value);
    end
    {d1_hit, d1_val} = cdb_lookup(dis_q1, cdb_valid, cdb_tag, cdb_value);
    {d2_hit, d2_val} = cdb_lookup(dis_q2, cdb_valid, cdb_tag, cdb_value);
  end

  always_comb begin
    logic found;
    logic blocked;
    ready    = '0;
    acc_mask = '0;
    sel_mask = '0;
    free_idx = '0;
    sel_idx  = '0;
    sel_any  = 1'b0;
    found    = 1'b0;
    blocked  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && (e_q1[i] == NO_DEP) && (e_q2[i] == NO_DEP);
    for (int unsigned i = 0; i < DEPTH; i++)
      if (!busy[i] && !found) begin
        found    = 1'b1;
        free_idx = IW'(i);
      end
    // A ready entry wins only if no other ready entry is older than it
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
      if (ready[i] && !blocked) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      acc_mask[i] = accept && (free_idx == IW'(i));
      sel_mask[i] = do_sel && (sel_idx == IW'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy      <= '0;
      count_out <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_opr1  <= '0;
      iss_opr2  <= '0;
      iss_tag   <= '1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_op[i]  <= '0;
        e_rob[i] <= '0;
        e_q1[i]  <= '1;
        e_q2[i]  <= '1;
        e_v1[i]  <= '0;
        e_v2[i]  <= '0;
        older[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy      <= '0;
        iss_valid <= 1'b0;
        count_out <= '0;
      end else begin
        busy      <= (busy | acc_mask) & ~sel_mask;
        count_out <= count_out + CW'(accept) - CW'(do_sel);
        for (int unsigned i = 0; i < DEPTH; i++)
          if (busy[i]) begin
            if (w1_hit[i]) begin
              e_q1[i] <= '1;
              e_v1[i] <= w1_val[i];
            end
            if (w2_hit[i]) begin
              e_q2[i] <= '1;
              e_v2[i] <= w2_val[i];
            end
          end
        if (accept) begin
          e_op[free_idx]  <= dis_op;
          e_rob[free_idx] <= dis_rob_id;
          e_q1[free_idx]  <= d1_hit ? NO_DEP : dis_q1;
          e_v1[free_idx]  <= d1_hit ? d1_val : dis_v1;
          e_q2[free_idx]  <= d2_hit ? NO_DEP : dis_q2;
          e_v2[free_idx]  <= d2_hit ? d2_val : dis_v2;
          older[free_idx] <= '0;
          for (int unsigned j = 0; j < DEPTH; j++)
            if (IW'(j) != free_idx) older[j][free_idx] <= 1'b1;
        end
        if (advance) begin
          iss_valid <= sel_any;
          if (sel_any) begin
            iss_op   <= e_op[sel_idx];
            iss_opr1 <= e_v1[sel_idx];
            iss_opr2 <= e_v2[sel_idx];
            iss_tag  <= {1'b0, e_rob[sel_idx]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios plus random traffic, checked every cycle
// against an age-ordered queue model of the station.
module tb_rs_multi_cdb;
  localparam int DEPTH = 8;
  localparam int ROB_W = 3;
  localparam int NUM_CDB = 2;
  localparam int OP_W = 5;
  localparam logic [3:0] NODEP = 4'hF;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        dis_valid;
  logic [4:0]  dis_op;
  logic [2:0]  dis_rob_id;
  logic [3:0]  dis_q1, dis_q2;
  logic [31:0] dis_v1, dis_v2;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_op;
  logic [31:0] iss_opr1, iss_opr2;
  logic [3:0]  iss_tag;
  logic [3:0]  count_out;
  logic        full_out;

  rs_multi_cdb #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .dis_valid(dis_valid), .dis_op(dis_op), .dis_rob_id(dis_rob_id),
    .dis_q1(dis_q1), .dis_q2(dis_q2), .dis_v1(dis_v1), .dis_v2(dis_v2),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_opr1(iss_opr1), .iss_opr2(iss_opr2), .iss_tag(iss_tag),
    .count_out(count_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rob;
    logic [3:0]  q1, q2;
    logic [31:0] v1, v2;
  } ent_t;

  ent_t        m_q[$];
  logic        m_iv;
  logic [4:0]  m_op;
  logic [31:0] m_o1, m_o2;
  logic [3:0]  m_tag;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_iv = 1'b0; m_op = '0; m_o1 = '0; m_o2 = '0; m_tag = NODEP;
  endtask

  function automatic logic [32:0] lookup(input logic [3:0] q);
    if (q == NODEP) return '0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == q) return {1'b1, cdb_value[k*32 +: 32]};
    return '0;
  endfunction

  task automatic model_step();
    int sel;
    int n;
    ent_t e;
    logic [32:0] r;
    if (!rst_n_in || !rdy_in) return;
    if (flush_in) begin
      m_q.delete();
      m_iv = 1'b0;
      return;
    end
    n = m_q.size();
    sel = -1;
    foreach (m_q[i]) if (sel < 0 && m_q[i].q1 == NODEP && m_q[i].q2 == NODEP) sel = i;
    if (!m_iv || iss_ready) begin
      if (sel >= 0) begin
        m_iv = 1'b1; m_op = m_q[sel].op; m_o1 = m_q[sel].v1; m_o2 = m_q[sel].v2;
        m_tag = {1'b0, m_q[sel].rob};
        m_q.delete(sel);
      end else m_iv = 1'b0;
    end
    foreach (m_q[i]) begin
      e = m_q[i];
      r = lookup(e.q1); if (r[32]) begin e.q1 = NODEP; e.v1 = r[31:0]; end
      r = lookup(e.q2); if (r[32]) begin e.q2 = NODEP; e.v2 = r[31:0]; end
      m_q[i] = e;
    end
    if (dis_valid && n < DEPTH) begin
      e.op = dis_op; e.rob = dis_rob_id; e.q1 = dis_q1; e.q2 = dis_q2; e.v1 = dis_v1; e.v2 = dis_v2;
      r = lookup(e.q1); if (r[32]) begin e.q1 = NODEP; e.v1 = r[31:0]; end
      r = lookup(e.q2); if (r[32]) begin e.q2 = NODEP; e.v2 = r[31:0]; end
      m_q.push_back(e);
    end
  endtask

  task automatic compare_all();
    chk("iss_valid", iss_valid, m_iv);
    chk("iss_op", iss_op, m_op);
    chk("iss_opr1", iss_opr1, m_o1);
    chk("iss_opr2", iss_opr2, m_o2);
    chk("iss_tag", iss_tag, m_tag);
    chk("count_out", count_out, m_q.size());
    chk("full_out", full_out, m_q.size() == DEPTH);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; dis_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [2:0] rob, input logic [3:0] q1,
                          input logic [3:0] q2, input logic [31:0] v1, input logic [31:0] v2);
    dis_valid = 1'b1; dis_op = op; dis_rob_id = rob;
    dis_q1 = q1; dis_q2 = q2; dis_v1 = v1; dis_v2 = v2;
  endtask

  task automatic bcast(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch] = 1'b1; cdb_tag[ch*4 +: 4] = tag; cdb_value[ch*32 +: 32] = val;
  endtask

  initial begin
    rst_n_in = 1'b0; iss_ready = 1'b1;
    cdb_tag = '0; cdb_value = '0;
    dis_op = '0; dis_rob_id = '0; dis_q1 = NODEP; dis_q2 = NODEP; dis_v1 = '0; dis_v2 = '0;
    idle();
    model_reset();
    cycle(); cycle();
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_iss_tag", iss_tag, 4'hF);
    chk("reset_count", count_out, 0);
    rst_n_in = 1'b1;

    // 1: ready op issues one edge after dispatch
    dispatch(5'd3, 3'd2, NODEP, NODEP, 32'd5, 32'd7);
    cycle();
    chk("t1_count_after_dis", count_out, 1);
    idle(); cycle();
    chk("t1_valid", iss_valid, 1); chk("t1_opr1", iss_opr1, 5); chk("t1_opr2", iss_opr2, 7);
    chk("t1_tag", iss_tag, 4'h2); chk("t1_op", iss_op, 3); chk("t1_count", count_out, 0);

    // 2: wakeup on channel 1, issue two edges after the broadcast
    dispatch(5'd1, 3'd1, 4'h4, NODEP, 32'd0, 32'h11);
    cycle(); idle(); cycle();
    bcast(1, 4'h4, 32'hDEAD); cycle(); idle();
    chk("t2_not_yet", iss_valid, 0);
    cycle();
    chk("t2_valid", iss_valid, 1); chk("t2_opr1", iss_opr1, 32'hDEAD); chk("t2_tag", iss_tag, 4'h1);

    // 3: same-cycle bypass from channel 0
    dispatch(5'd2, 3'd3, NODEP, 4'h5, 32'd1, 32'd0);
    bcast(0, 4'h5, 32'd9);
    cycle(); idle(); cycle();
    chk("t3_valid", iss_valid, 1); chk("t3_opr2", iss_opr2, 9); chk("t3_tag", iss_tag, 4'h3);

    // 4: fill, drop when full, drain in order
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(5'(i), 3'(i), NODEP, NODEP, 32'(100 + i), 32'(200 + i));
      cycle();
    end
    chk("t4_full", full_out, 1); chk("t4_count", count_out, 8);
    dispatch(5'd9, 3'd7, NODEP, NODEP, 32'd999, 32'd999);
    cycle();
    chk("t4_drop_count", count_out, 8);
    idle(); iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("t4_order_tag", iss_tag, 4'(i)); chk("t4_order_opr1", iss_opr1, 32'(100 + i));
    end
    cycle();
    chk("t4_empty", iss_valid, 0);

    // 5: wakeup order vs age, slot reuse
    iss_ready = 1'b0;
    dispatch(5'd4, 3'd4, 4'h1, NODEP, 32'd0, 32'h44); cycle();
    dispatch(5'd5, 3'd5, 4'h2, NODEP, 32'd0, 32'h55); cycle();
    idle(); bcast(0, 4'h2, 32'hB0); cycle();
    idle(); bcast(0, 4'h1, 32'hA0); cycle();
    chk("t5_b_held", iss_tag, 4'h5); chk("t5_b_opr1", iss_opr1, 32'hB0);
    idle(); dispatch(5'd6, 3'd6, NODEP, NODEP, 32'h66, 32'h67); cycle();
    idle(); cycle();
    chk("t5_b_stable", iss_tag, 4'h5);
    iss_ready = 1'b1;
    cycle(); chk("t5_a_tag", iss_tag, 4'h4); chk("t5_a_opr1", iss_opr1, 32'hA0);
    cycle(); chk("t5_c_tag", iss_tag, 4'h6);
    cycle(); chk("t5_done", iss_valid, 0);

    // 6: flush, then asynchronous reset mid-cycle
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dispatch(5'(i), 3'(i), NODEP, NODEP, 32'(i), 32'(i)); cycle();
    end
    idle();
    chk("t6_count5", count_out, 5); chk("t6_valid", iss_valid, 1);
    flush_in = 1'b1; cycle(); flush_in = 1'b0;
    chk("t6_flush_count", count_out, 0); chk("t6_flush_valid", iss_valid, 0);
    dispatch(5'd7, 3'd2, NODEP, NODEP, 32'd70, 32'd71); cycle();
    dispatch(5'd8, 3'd3, NODEP, NODEP, 32'd80, 32'd81); cycle();
    idle();
    #2 rst_n_in = 1'b0; model_reset();
    #1;
    chk("t6_rst_valid", iss_valid, 0); chk("t6_rst_count", count_out, 0);
    chk("t6_rst_tag", iss_tag, 4'hF); chk("t6_rst_opr1", iss_opr1, 0);
    cycle();
    rst_n_in = 1'b1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      flush_in  = ($urandom_range(0, 49) == 0);
      iss_ready = ($urandom_range(0, 9) < 6);
      dis_valid = ($urandom_range(0, 9) < 6);
      dis_op    = 5'($urandom);
      dis_rob_id = 3'($urandom);
      dis_q1 = ($urandom_range(0, 1) == 0) ? NODEP : 4'($urandom_range(0, 7));
      dis_q2 = ($urandom_range(0, 1) == 0) ? NODEP : 4'($urandom_range(0, 7));
      dis_v1 = $urandom; dis_v2 = $urandom;
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*4 +: 4] = 4'($urandom_range(0, 7));
        cdb_value[k*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n_in = 1'b0; model_reset();
      end else rst_n_in = 1'b1;
      cycle();
    end
    rst_n_in = 1'b1; idle(); iss_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bcast(0, 4'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised reservation station for the integer pipeline. It holds up to DEPTH dispatched ALU ops and captures operands from NUM_CDB broadcast channels (ALU, LSB, and later units). It selects the oldest ready entry and issues it to the ALU through a registered valid/ready handshake that can stall. It sits between the decoder/dispatch stage and the ALU. Tag convention: a ROB_W+1-bit tag of all-ones means "no dependency" (value valid).

Parameters:
DEPTH, 8, number of entries; must be ≥2.
ROB_W, 3, ROB index width; tags are ROB_W+1 bits.
NUM_CDB, 2, number of result broadcast channels.
OP_W, 5, opcode field width ({op_L1, op_L2} packed by dispatch).

Ports:
clk_in  in  1  clock; all state updates on rising edge.
rst_n_in  in  1  reset; asynchronous, active-low.
rdy_in  in  1  global enable; low = hold all state and outputs.
flush_in  in  1  mispredict flush; synchronous.
cdb_valid  in  NUM_CDB  per-channel result valid.
cdb_tag  in  NUM_CDB*(ROB_W+1)  per-channel producer tag; channel k occupies bits [k*(ROB_W+1) +: ROB_W+1].
cdb_value  in  NUM_CDB*32  per-channel result; channel k occupies bits [k*32 +: 32].
dis_valid  in  1  dispatch request.
dis_op  in  OP_W  operation.
dis_rob_id  in  ROB_W  destination ROB index.
dis_q1, dis_q2  in  ROB_W+1 each  operand tags, already resolved against RF/ROB/immediate; all-ones = ready.
dis_v1, dis_v2  in  32 each  operand values; meaningful only when the matching tag is all-ones.
iss_valid  out  1  issue register holds an op.
iss_ready  in  1  ALU accepts the op this cycle.
iss_op  out  OP_W  issued operation.
iss_opr1, iss_opr2  out  32 each  issued operands.
iss_tag  out  ROB_W+1  {1'b0, rob_id} of the issued op.
count_out  out  $clog2(DEPTH)+1  occupied entries, registered.
full_out  out  1  combinational: count_out == DEPTH.

Behaviour:
- Async reset (rst_n_in=0):
  - all entries not busy; entry tags all-ones; count 0.
  - iss_valid=0, iss_op=0, iss_opr1=0, iss_opr2=0, iss_tag=all-ones.
  - Applies immediately and overrides rdy_in and flush_in; deasserting mid-operation resumes from the empty state.
- rdy_in=0: no state changes. CDB broadcasts and dispatches in that cycle are lost; the producer side guarantees it does not drive them.
- flush_in=1 (with rdy_in=1):
  - next edge clears all busy bits, iss_valid, and count.
  - dispatch, wakeup, and selection are ignored that cycle.
- Dispatch acceptance: dis_valid & !full_out. A request while full is dropped; the upstream stage must stall on full_out. A slot freed by issue is not reusable in the same cycle. The new entry goes to the lowest-index free slot.
- Dispatch bypass: each incoming operand whose tag is not all-ones is compared against every valid CDB channel in the same cycle. On a match, the entry stores the CDB value with an all-ones tag. If several channels match, the lowest channel index wins.
- Wakeup: each busy entry compares its q1 and q2 against every valid channel. On a match it captures the value and sets the tag to all-ones. A single CDB may wake both operands and many entries. A dispatch and a wakeup never target the same entry in one cycle.
- Ready: busy with both registered tags all-ones. Readiness is evaluated on registered state only.
  - CDB wakeup at edge t → selectable in cycle t+1 → iss_valid at edge t+2 at the earliest.
  - Dispatch of an already-ready op at edge t → iss_valid at edge t+1 at the earliest.
- Selection: the oldest ready entry, in dispatch order (age matrix or sequence stamps; ties impossible). Age is preserved across out-of-order frees.
- Issue register:
  - Loaded when (!iss_valid | iss_ready) and a ready entry exists. That entry's busy bit is cleared at the same edge.
  - If (!iss_valid | iss_ready) and no ready entry exists, iss_valid←0.
  - While iss_valid & !iss_ready, all iss_* outputs hold stable and nothing is selected.
- Count: count_next = count + accept − select. It stays within 0..DEPTH. Simultaneous accept and select at full is impossible because accept requires !full.

Test Plan:
1. Reset, then dispatch op=3 with rob 2, q1=q2=all-ones, v1=5, v2=7 → iss_valid at the next edge with opr1=5, opr2=7, iss_tag=0x02, op=3; count_out returns to 0 after the issue.
2. Dispatch rob 1 with q1=0x04 pending. Two cycles later, cdb_valid[1]=1, tag 0x04, value 0xDEAD → iss_valid exactly 2 edges after the broadcast, opr1=0xDEAD.
3. Dispatch with q2=0x05 while CDB channel 0 broadcasts tag 0x05, value 9 in the same cycle → the entry is ready immediately and issues next edge with opr2=9 (bypass).
4. Fill to DEPTH=8 with iss_ready=0 → full_out=1, count_out=8, and a 9th dispatch is dropped. Then raise iss_ready=1 → entries issue oldest-first in dispatch order, one per cycle.
5. Pending entries A (older) and B: wake B first, then A, while iss_ready=0. Release iss_ready → B is issued first (already held in the issue register), then A. Ages stay correct after the B slot is reused by a new dispatch C: A issues before C.
6. Five busy entries with iss_valid=1, assert flush_in for one cycle → count_out=0, iss_valid=0 next edge. Then pull rst_n_in low mid-cycle → outputs go to reset values before the next clock edge.
